// File: rtl/decoder_scan_seq.sv
// Select-code scan sequencer feeding a 2-to-4 decoder: steps {sel_a,sel_b}
// through 0..3, holding each code for a latched dwell, single or continuous.
module decoder_scan_seq #(
  parameter int DWELL_W = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_stop,
  output logic               o_sel_a,
  output logic               o_sel_b,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_wrap,
  output logic [SWEEP_W-1:0] o_sweep_cnt
);

  // state | meaning
  // IDLE  | waiting for start, select parked at 00
  // RUN   | code idx live, dwell counter running
  // DONE  | one-cycle completion pulse after a single sweep
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_idx;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell_l;
  logic               r_mode_l;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_wrap;
  logic [SWEEP_W-1:0] r_sweep_cnt;

  // idx is forced to 0 whenever the FSM leaves RUN, so it doubles as the select register
  assign o_sel_a     = r_idx[1];
  assign o_sel_b     = r_idx[0];
  assign o_valid     = r_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wrap      = r_wrap;
  assign o_sweep_cnt = r_sweep_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_dwell_l   <= DWELL_W'(1);
      r_mode_l    <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
      r_sweep_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_RUN;
            r_dwell_l   <= (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
            r_cnt       <= (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
            r_mode_l    <= i_mode;
            r_idx       <= 2'd0;
            r_sweep_cnt <= '0;
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (r_idx != 2'd3) begin
            r_idx <= r_idx + 2'd1;
            r_cnt <= r_dwell_l - DWELL_W'(1);
          end else begin
            r_idx       <= 2'd0;
            r_sweep_cnt <= r_sweep_cnt + SWEEP_W'(1);
            if (r_mode_l) begin
              r_cnt  <= r_dwell_l - DWELL_W'(1);
              r_wrap <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_cnt   <= '0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= 2'd0;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq: single sweep, zero dwell, continuous
// wrap, stop, ignored restart and mid-sweep reset.
module tb_decoder_scan_seq;
  localparam int DW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, mode, stop;
  logic [DW-1:0] dwell;
  logic          sel_a, sel_b, valid, busy, done, wrap;
  logic [SW-1:0] sweep_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decoder_scan_seq #(.DWELL_W(DW), .SWEEP_W(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_dwell(dwell), .i_stop(stop),
    .o_sel_a(sel_a), .o_sel_b(sel_b), .o_valid(valid), .o_busy(busy),
    .o_done(done), .o_wrap(wrap), .o_sweep_cnt(sweep_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_sel, input bit e_v, input bit e_b,
                         input bit e_d, input bit e_w, input int e_sc);
    chk({tag, ".sel"},   32'({sel_a, sel_b}), 32'(e_sel));
    chk({tag, ".valid"}, 32'(valid), 32'(e_v));
    chk({tag, ".busy"},  32'(busy), 32'(e_b));
    chk({tag, ".done"},  32'(done), 32'(e_d));
    chk({tag, ".wrap"},  32'(wrap), 32'(e_w));
    chk({tag, ".sweep"}, 32'(sweep_cnt), 32'(e_sc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; stop = 1'b0; dwell = '0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_all("idle0", 0, 0, 0, 0, 0, 0);

    // single sweep, dwell=3; restart attempt mid-run with dwell=7 mode=1 is ignored
    dwell = 8'd3; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk_all($sformatf("s1.c%0d", k), k / 3, 1, 1, 0, 0, 0);
      if (k == 5) begin start = 1'b1; dwell = 8'd7; mode = 1'b1; end
      if (k == 6) begin start = 1'b0; end
      step();
    end
    chk_all("s1.done", 0, 0, 1, 1, 0, 1);
    start = 1'b1;
    step();
    chk_all("s1.idle", 0, 0, 0, 0, 0, 1);
    start = 1'b0;

    // dwell=0 behaves as dwell=1
    dwell = 8'd0; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_all($sformatf("d0.c%0d", k), k, 1, 1, 0, 0, 0);
      step();
    end
    chk_all("d0.done", 0, 0, 1, 1, 0, 1);
    step();
    chk_all("d0.idle", 0, 0, 0, 0, 0, 1);

    // continuous, dwell=2: wrap every 8 cycles, sweep_cnt wraps mod 4; stop at idx=2, cnt=1
    dwell = 8'd2; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c <= 44; c++) begin
      chk_all($sformatf("cont.c%0d", c), (c % 8) / 2, 1, 1, 0,
              (c % 8 == 0) && (c > 0), (c / 8) % 4);
      if (c == 44) stop = 1'b1;
      step();
    end
    chk_all("stop", 0, 0, 0, 0, 0, 1);
    stop = 1'b0;
    step();
    chk_all("stop.idle", 0, 0, 0, 0, 0, 1);

    // reset for one edge while idx=3 in continuous mode, with start held high
    dwell = 8'd2; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("r.sel%0d", c), 32'({sel_a, sel_b}), 32'(c / 2));
      step();
    end
    chk("r.sel_pre", 32'({sel_a, sel_b}), 32'd3);
    rst_n = 1'b0; start = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0;
    chk_all("rst.mid", 0, 0, 0, 0, 0, 0);

    // start and stop together in IDLE: start wins
    dwell = 8'd1; mode = 1'b0; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_all($sformatf("rs.c%0d", k), k, 1, 1, 0, 0, 0);
      step();
    end
    chk_all("rs.done", 0, 0, 1, 1, 0, 1);
    step();
    chk_all("rs.idle", 0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
